// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the count/thermometer blocks, plus the
// state encoding of the thermometer decoder FSM.
//   log2floor(v)  : floor(log2(v)), 0 for v <= 1
//   ceil_div(a,b) : ceil(a/b)
//   cnt_width(d)  : width of a population count over d bits
package arith_pkg;

  function automatic int unsigned log2floor(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((v >> i) != 0) r = i;
    end
    return r;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return log2floor(depth) + 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } thermo_state_e;

endpackage

// File: rtl/thermo_slice.sv
// One width-bit window of a thermometer code.
//   cnt_i   : number of leading ones in the full vector
//   base_i  : bit position of slice bit 0 within the full vector
//   slice_o : bit j set iff base_i + j < cnt_i
module thermo_slice #(
  parameter int unsigned width = 8,
  parameter int unsigned cw    = 5
) (
  input  logic [cw-1:0]    cnt_i,
  input  logic [cw-1:0]    base_i,
  output logic [width-1:0] slice_o
);

  // One extra bit so base + j cannot wrap for the final beat.
  typedef logic [cw:0] sum_t;

  always_comb begin
    slice_o = '0;
    for (int unsigned j = 0; j < width; j++) begin
      slice_o[j] = (sum_t'(base_i) + sum_t'(j)) < sum_t'(cnt_i);
    end
  end

endmodule

// File: rtl/cnt_thermo_decoder.sv
// Count -> thermometer decoder, streamed out in width-bit beats.
// A count C arrives on the in_* handshake; the depth-bit vector with bits
// [min(C,depth)-1:0] set is then emitted as ceil(depth/width) beats on the
// out_* handshake, lowest bits first.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   in_valid_i/in_ready_o     : count handshake
//   in_cnt_i                  : count C (Cnt sum width)
//   out_valid_o/out_ready_i   : beat handshake
//   out_data_o                : thermometer slice of the current beat
//   out_idx_o                 : beat index 0..NB-1
//   out_last_o                : final beat of the vector
//   out_sat_o                 : C exceeded depth (held for the whole vector)
// speed=0 accepts the next count combinationally on the last-beat accept;
// speed=1 parks an early count in a skid register so in_ready_o is a pure
// register output.
module cnt_thermo_decoder
  import arith_pkg::*;
#(
  parameter int unsigned depth = 18,
  parameter int unsigned width = 8,
  parameter int unsigned speed = 0
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         in_valid_i,
  output logic                                         in_ready_o,
  input  logic [cnt_width(depth)-1:0]                  in_cnt_i,
  output logic                                         out_valid_o,
  input  logic                                         out_ready_i,
  output logic [width-1:0]                             out_data_o,
  output logic [log2floor(ceil_div(depth, width)-1):0] out_idx_o,
  output logic                                         out_last_o,
  output logic                                         out_sat_o
);

  localparam int unsigned CW = cnt_width(depth);
  localparam int unsigned NB = ceil_div(depth, width);
  localparam int unsigned IW = log2floor(NB - 1) + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(depth);
  localparam logic [CW-1:0] WIDTH_C  = CW'(width);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  thermo_state_e   state_q, state_d;
  logic [CW-1:0]   csat_q,  csat_d;
  logic [CW-1:0]   base_q,  base_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic            last_q,  last_d;
  logic            sat_q,   sat_d;
  logic [width-1:0] data_q, data_d;

  logic            src_valid;
  logic [CW-1:0]   src_cnt;
  logic [CW-1:0]   src_csat;
  logic            core_ready;
  logic            core_load;
  logic            out_fire;
  logic [CW-1:0]   slice_cnt;
  logic [CW-1:0]   slice_base;
  logic [width-1:0] slice_data;

  // The core can take a new count when idle, or when its final beat is
  // being consumed this cycle (back-to-back vectors without a bubble).
  assign core_ready = (state_q == ST_IDLE) | (out_ready_i & last_q);
  assign core_load  = src_valid & core_ready;
  assign out_fire   = (state_q == ST_SEND) & out_ready_i;

  assign src_csat = (src_cnt > DEPTH_C) ? DEPTH_C : src_cnt;

  // One slice generator serves both the first beat of a freshly loaded
  // count and every following beat of the current vector.
  assign slice_cnt  = core_load ? src_csat : csat_q;
  assign slice_base = core_load ? '0 : base_q + WIDTH_C;

  thermo_slice #(
    .width (width),
    .cw    (CW)
  ) u_slice (
    .cnt_i   (slice_cnt),
    .base_i  (slice_base),
    .slice_o (slice_data)
  );

  if (speed != 0) begin : g_skid
    logic          skid_full_q, skid_full_d;
    logic [CW-1:0] skid_cnt_q,  skid_cnt_d;
    logic          in_fire;

    // Counts are taken whenever the skid slot is free; one that arrives
    // while the core is busy waits there until the core can load it.
    assign in_ready_o = ~rst_i & ~skid_full_q;
    assign in_fire    = in_valid_i & in_ready_o;
    assign src_valid  = skid_full_q | in_valid_i;
    assign src_cnt    = skid_full_q ? skid_cnt_q : in_cnt_i;

    always_comb begin
      skid_full_d = skid_full_q;
      skid_cnt_d  = skid_cnt_q;
      if (skid_full_q) begin
        if (core_load) skid_full_d = 1'b0;
      end else if (in_fire && !core_load) begin
        skid_full_d = 1'b1;
        skid_cnt_d  = in_cnt_i;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        skid_full_q <= 1'b0;
        skid_cnt_q  <= '0;
      end else begin
        skid_full_q <= skid_full_d;
        skid_cnt_q  <= skid_cnt_d;
      end
    end
  end else begin : g_direct
    assign in_ready_o = ~rst_i & core_ready;
    assign src_valid  = in_valid_i;
    assign src_cnt    = in_cnt_i;
  end

  always_comb begin
    state_d = state_q;
    csat_d  = csat_q;
    base_d  = base_q;
    idx_d   = idx_q;
    last_d  = last_q;
    sat_d   = sat_q;
    data_d  = data_q;
    if (core_load) begin
      state_d = ST_SEND;
      csat_d  = src_csat;
      sat_d   = src_cnt > DEPTH_C;
      base_d  = '0;
      idx_d   = '0;
      last_d  = (LAST_IDX == '0);
      data_d  = slice_data;
    end else if (out_fire) begin
      if (last_q) begin
        state_d = ST_IDLE;
        csat_d  = '0;
        sat_d   = 1'b0;
        base_d  = '0;
        idx_d   = '0;
        last_d  = 1'b0;
        data_d  = '0;
      end else begin
        base_d  = base_q + WIDTH_C;
        idx_d   = idx_q + 1'b1;
        last_d  = (idx_q + 1'b1) == LAST_IDX;
        data_d  = slice_data;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      csat_q  <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      sat_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      csat_q  <= csat_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      sat_q   <= sat_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = (state_q == ST_SEND);
  assign out_data_o  = data_q;
  assign out_idx_o   = idx_q;
  assign out_last_o  = last_q;
  assign out_sat_o   = sat_q;

endmodule
